// File: rtl/comparator_decimator.sv
// comparator_decimator: counts high comparator decisions per channel over a window and streams the snapshot out
// Define CMP_SYNC3_EN for 3-FF input synchronizers (2-FF otherwise).
module comparator_decimator #(
  parameter int N_CH = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N_CH-1:0]  high_buf,
  input  logic [N_CH-1:0]  phi1b_dig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             overrun
);
`ifdef CMP_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nx;
  logic [SYNC_N+1:0][N_CH-1:0] ph_q;
  logic [SYNC_N:0][N_CH-1:0] hb_q;
  logic [N_CH-1:0] inc;
  logic [N_CH-1:0][CNT_W-1:0] cnt, cnt_nx, snap_q;
  logic [WIN_W-1:0] timer, wl_q, wl;
  logic [CH_W-1:0] ch_q, ch_nx;
  logic snap, accept, last, done, snap_load, ovr_set;
  // one stage past the synchronizer output registers the edge detect
  always_ff @(posedge clk)
    if (!rstb) begin
      ph_q <= '0;
      hb_q <= '0;
    end else begin
      ph_q <= {ph_q[SYNC_N:0], phi1b_dig};
      hb_q <= {hb_q[SYNC_N-1:0], high_buf};
    end
  assign inc = ph_q[SYNC_N] & ~ph_q[SYNC_N+1] & hb_q[SYNC_N];
  always_comb begin
    cnt_nx = cnt;
    for (int c = 0; c < N_CH; c++)
      cnt_nx[c] = (inc[c] && cnt[c] != '1) ? cnt[c] + CNT_W'(1) : cnt[c];
  end
  // window length is taken live on the first cycle of a window, then held
  assign wl = (timer == '0) ? win_len : wl_q;
  assign snap = en && (timer == wl);
  always_ff @(posedge clk)
    if (!rstb) begin
      timer <= '0;
      wl_q <= '0;
      cnt <= '0;
    end else begin
      if (timer == '0) wl_q <= win_len;
      timer <= (!en || snap) ? '0 : timer + WIN_W'(1);
      cnt <= (!en || snap) ? '0 : cnt_nx;
    end
  assign accept = (state == DRAIN) && out_ready;
  assign last = ch_q == CH_W'(N_CH - 1);
  assign done = (state == IDLE) || (accept && last);
  always_comb begin
    snap_load = snap && done;
    ovr_set = snap && !done;
    state_nx = snap_load ? DRAIN : (accept && last) ? IDLE : state;
    ch_nx = done ? '0 : accept ? ch_q + CH_W'(1) : ch_q;
  end
  always_ff @(posedge clk)
    if (!rstb) begin
      state <= IDLE;
      ch_q <= '0;
      snap_q <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      ch_q <= ch_nx;
      if (snap_load) snap_q <= cnt_nx;
      if (ovr_set) overrun <= 1'b1;
    end
  assign out_valid = state == DRAIN;
  assign out_ch = ch_q;
  assign out_data = snap_q[ch_q];
  assign out_last = out_valid && last;
endmodule
